// File: rtl/fir_decim_out.sv
// fir_decim_out
// Output stage behind the 3-tap FIR. It block-averages every DECIM valid
// samples (boxcar decimation), applies a round-half-up right shift of
// L+SHIFT bits and saturates the result to 8 bits. Results are queued in a
// show-ahead FIFO, so a slow consumer never stalls the filter.
//
// Parameters:
//   DECIM  decimation factor, power of two 1..16 (L = log2(DECIM))
//   SHIFT  extra scaling right shift after averaging, 0..8
//   DEPTH  FIFO depth in words, power of two 2..16 (A = log2(DEPTH))
// Ports:
//   Clk         clock, rising edge
//   Rst         synchronous active-high reset
//   Yin         16-bit unsigned filtered sample
//   Yin_valid   Yin carries a new sample this cycle
//   Dout        FIFO head word (0 while empty)
//   Dout_valid  FIFO non-empty
//   Dout_ready  consumer takes Dout this cycle
//   Fill        registered FIFO occupancy, 0..DEPTH
//   Ovf         sticky flag: a result was dropped on a full FIFO
module fir_decim_out #(
    parameter int DECIM = 4,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [15:0]                Yin,
    input  logic                       Yin_valid,
    output logic [7:0]                 Dout,
    output logic                       Dout_valid,
    input  logic                       Dout_ready,
    output logic [$clog2(DEPTH):0]     Fill,
    output logic                       Ovf
);

    localparam int L  = $clog2(DECIM);
    localparam int A  = $clog2(DEPTH);
    localparam int N  = L + SHIFT;
    localparam int AW = 16 + L;
    localparam int SW = 17 + L;

    logic [AW-1:0] acc;
    logic          block_last;
    logic          produce;
    logic [SW-1:0] sum;
    logic [SW-1:0] r;
    logic [7:0]    result;

    logic [7:0]    mem [DEPTH];
    logic [A:0]    wr_ptr;
    logic [A:0]    rd_ptr;
    logic          full;
    logic          pop;
    logic          push;

    // Phase counter marks the last sample of each block. With DECIM=1 every
    // valid sample completes a block, so no counter exists at all.
    generate
        if (L > 0) begin : g_phase
            logic [L-1:0] ph;

            assign block_last = (ph == L'(DECIM - 1));

            always_ff @(posedge Clk) begin
                if (Rst) begin
                    ph <= '0;
                end else if (Yin_valid) begin
                    ph <= block_last ? '0 : ph + 1'b1;
                end
            end
        end else begin : g_no_phase
            assign block_last = 1'b1;
        end
    endgenerate

    assign produce = Yin_valid & block_last;

    // The completed block sum includes the current sample without waiting
    // for it to land in acc; acc restarts from zero for the next block.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc <= '0;
        end else if (Yin_valid) begin
            acc <= block_last ? '0 : acc + AW'(Yin);
        end
    end

    assign sum = SW'(acc) + SW'(Yin);

    // One extra bit of headroom keeps the rounding carry when the sum is
    // near full scale (e.g. 4 x 0xFFFF rounds up to 256 before saturating).
    generate
        if (N > 0) begin : g_round
            assign r = (sum + (SW'(1) << (N - 1))) >> N;
        end else begin : g_no_round
            assign r = sum;
        end
    endgenerate

    assign result = (r > SW'(255)) ? 8'hFF : r[7:0];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push when the consumer is draining it.
    assign full       = (Fill == (A + 1)'(DEPTH));
    assign Dout_valid = (Fill != '0);
    assign pop        = Dout_valid & Dout_ready;
    assign push       = produce & (~full | pop);

    // Storage has no reset; Dout is masked while empty so it reads 0 then.
    always_ff @(posedge Clk) begin
        if (!Rst && push) begin
            mem[wr_ptr[A-1:0]] <= result;
        end
    end

    assign Dout = Dout_valid ? mem[rd_ptr[A-1:0]] : 8'h00;

    // Pointers wrap modulo 2*DEPTH; Fill is kept as its own register so the
    // occupancy seen by the consumer is a clean flop output.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Fill   <= '0;
            Ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   Fill <= Fill + 1'b1;
                2'b01:   Fill <= Fill - 1'b1;
                default: Fill <= Fill;
            endcase
            if (produce && !push) begin
                Ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out
// Scoreboard bench for fir_decim_out. The driver feeds samples through a
// high-level model (block list summed with plain arithmetic, FIFO as a
// queue) and pushes accepted results into exp_q; a negedge monitor pops and
// compares whenever the DUT hands a word to the consumer. A second instance
// (DECIM=1, SHIFT=0, DEPTH=2) covers the pass-through saturation case.
module tb_fir_decim_out;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] Yin;
    logic        Yin_valid;
    logic [7:0]  Dout;
    logic        Dout_valid;
    logic        Dout_ready;
    logic [2:0]  Fill;
    logic        Ovf;

    logic [15:0] Yin2;
    logic        Yin2_valid;
    logic [7:0]  Dout2;
    logic        Dout2_valid;
    logic        Dout2_ready;
    logic [1:0]  Fill2;
    logic        Ovf2;

    int n_vec = 0;
    int n_err = 0;

    int mdl_count;
    bit mdl_ovf;
    int blk[$];
    int exp_q[$];

    always #5 Clk = ~Clk;

    fir_decim_out #(.DECIM(4), .SHIFT(8), .DEPTH(4)) dut (
        .Clk(Clk), .Rst(Rst), .Yin(Yin), .Yin_valid(Yin_valid),
        .Dout(Dout), .Dout_valid(Dout_valid), .Dout_ready(Dout_ready),
        .Fill(Fill), .Ovf(Ovf)
    );

    fir_decim_out #(.DECIM(1), .SHIFT(0), .DEPTH(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .Yin(Yin2), .Yin_valid(Yin2_valid),
        .Dout(Dout2), .Dout_valid(Dout2_valid), .Dout_ready(Dout2_ready),
        .Fill(Fill2), .Ovf(Ovf2)
    );

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Visible state after an edge must match the queue model.
    task automatic checkOutput(input string tag);
        chk({tag, ".valid"}, int'(Dout_valid), int'(mdl_count > 0));
        chk({tag, ".fill"}, int'(Fill), mdl_count);
        chk({tag, ".ovf"}, int'(Ovf), int'(mdl_ovf));
        if (mdl_count > 0 && exp_q.size() > 0) begin
            chk({tag, ".head"}, int'(Dout), exp_q[0]);
        end
    endtask

    // One clock of stimulus; the model decides production, acceptance and drop.
    task automatic applyStimulus(input logic v, input logic [15:0] y, input logic rdy,
                                 input string tag);
        bit pop_m;
        bit res;
        int val;
        longint s;
        Yin_valid  = v;
        Yin        = y;
        Dout_ready = rdy;
        pop_m = rdy && (mdl_count > 0);
        res   = 1'b0;
        val   = 0;
        if (v) begin
            blk.push_back(int'(y));
            if (blk.size() == 4) begin
                s = 0;
                foreach (blk[i]) s += blk[i];
                val = int'((s + 512) / 1024);
                if (val > 255) val = 255;
                blk.delete();
                res = 1'b1;
            end
        end
        if (res) begin
            if (mdl_count < 4 || pop_m) begin
                exp_q.push_back(val);
                mdl_count++;
            end else begin
                mdl_ovf = 1'b1;
            end
        end
        if (pop_m) mdl_count--;
        @(posedge Clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic applyReset(input logic v);
        Rst         = 1'b1;
        Yin_valid   = v;
        Yin         = 16'd9999;
        Dout_ready  = 1'b0;
        Yin2_valid  = 1'b0;
        Dout2_ready = 1'b0;
        @(posedge Clk);
        #1;
        Rst       = 1'b0;
        Yin_valid = 1'b0;
        exp_q.delete();
        blk.delete();
        mdl_count = 0;
        mdl_ovf   = 1'b0;
        chk("reset.valid", int'(Dout_valid), 0);
        chk("reset.fill", int'(Fill), 0);
        chk("reset.ovf", int'(Ovf), 0);
        chk("reset.dout", int'(Dout), 0);
    endtask

    task automatic feedBlock(input logic [15:0] y, input logic rdy, input string tag);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, y, rdy, tag);
    endtask

    // Monitor: every word the consumer takes must be the oldest expected one.
    always @(negedge Clk) begin
        if (!Rst && Dout_valid && Dout_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("[TB] FAIL pop: got %0d, expected no word at %0t", Dout, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(Dout) != e) begin
                    n_err++;
                    $display("[TB] FAIL pop: got %0d, expected %0d at %0t", Dout, e, $time);
                end
            end
        end
    end

    initial begin
        Rst = 1'b1; Yin = '0; Yin_valid = 1'b0; Dout_ready = 1'b0;
        Yin2 = '0; Yin2_valid = 1'b0; Dout2_ready = 1'b0;
        mdl_count = 0; mdl_ovf = 1'b0;
        applyReset(1'b1);

        $display("[TB] basic average");
        feedBlock(16'd1000, 1'b1, "basic");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'd0, 1'b1, "basic.idle");

        $display("[TB] rounding and saturation");
        feedBlock(16'd384, 1'b1, "round384");
        feedBlock(16'd383, 1'b1, "round383");
        feedBlock(16'd0, 1'b1, "zero");
        feedBlock(16'hFFFF, 1'b1, "sat");
        applyStimulus(1'b0, 16'd0, 1'b1, "sat.idle");

        $display("[TB] gapped input");
        applyStimulus(1'b1, 16'd100, 1'b1, "gap");
        applyStimulus(1'b0, 16'($urandom), 1'b1, "gap");
        applyStimulus(1'b0, 16'($urandom), 1'b1, "gap");
        applyStimulus(1'b1, 16'd200, 1'b1, "gap");
        applyStimulus(1'b0, 16'($urandom), 1'b1, "gap");
        applyStimulus(1'b1, 16'd300, 1'b1, "gap");
        applyStimulus(1'b1, 16'd400, 1'b1, "gap");
        applyStimulus(1'b0, 16'd0, 1'b1, "gap.idle");

        $display("[TB] full and overflow");
        for (int b = 1; b <= 5; b++) feedBlock(16'(256 * b), 1'b0, "ovf.fill");
        chk("ovf.fill_final", int'(Fill), 4);
        chk("ovf.flag", int'(Ovf), 1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'd0, 1'b1, "ovf.drain");
        chk("ovf.sticky", int'(Ovf), 1);

        $display("[TB] full with simultaneous pop");
        applyReset(1'b0);
        for (int b = 1; b <= 4; b++) feedBlock(16'(256 * b), 1'b0, "nodrop.fill");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'd1280, 1'b0, "nodrop.blk5");
        applyStimulus(1'b1, 16'd1280, 1'b1, "nodrop.last");
        applyStimulus(1'b0, 16'd0, 1'b0, "nodrop.hold");
        chk("nodrop.fill", int'(Fill), 4);
        chk("nodrop.ovf", int'(Ovf), 0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'd0, 1'b1, "nodrop.drain");

        $display("[TB] reset mid-block");
        applyStimulus(1'b1, 16'd5000, 1'b1, "midrst");
        applyStimulus(1'b1, 16'd5000, 1'b1, "midrst");
        applyReset(1'b1);
        feedBlock(16'd512, 1'b1, "midrst.after");
        applyStimulus(1'b0, 16'd0, 1'b1, "midrst.idle");

        $display("[TB] reset with 3 words queued");
        for (int b = 0; b < 3; b++) feedBlock(16'($urandom), 1'b0, "rst3.fill");
        chk("rst3.fill", int'(Fill), 3);
        applyReset(1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'd0, 1'b1, "rst3.empty");

        $display("[TB] pass-through instance");
        Yin2_valid = 1'b1; Yin2 = 16'd300; Dout2_ready = 1'b0;
        applyStimulus(1'b0, 16'd0, 1'b0, "idle");
        chk("d1.sat_valid", int'(Dout2_valid), 1);
        chk("d1.sat_dout", int'(Dout2), 255);
        chk("d1.fill1", int'(Fill2), 1);
        Yin2 = 16'd200;
        applyStimulus(1'b0, 16'd0, 1'b0, "idle");
        chk("d1.fill2", int'(Fill2), 2);
        chk("d1.head_hold", int'(Dout2), 255);
        Yin2_valid = 1'b0; Dout2_ready = 1'b1;
        applyStimulus(1'b0, 16'd0, 1'b0, "idle");
        chk("d1.second", int'(Dout2), 200);
        chk("d1.fill_pop", int'(Fill2), 1);
        Yin2_valid = 1'b1; Yin2 = 16'd77;
        applyStimulus(1'b0, 16'd0, 1'b0, "idle");
        chk("d1.pushpop", int'(Dout2), 77);
        chk("d1.fill_pp", int'(Fill2), 1);
        Yin2_valid = 1'b0;
        applyStimulus(1'b0, 16'd0, 1'b0, "idle");
        chk("d1.empty", int'(Dout2_valid), 0);
        chk("d1.ovf", int'(Ovf2), 0);
        Dout2_ready = 1'b0;

        $display("[TB] random traffic");
        applyReset(1'b0);
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic rdy;
            v   = ($urandom_range(0, 3) != 0);
            rdy = (i % 100 < 60) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            applyStimulus(v, 16'($urandom), rdy, "rand");
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'd0, 1'b1, "rand.drain");
        chk("rand.queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
